prog_loader: RTL

//  Serial program loader: the writer for the CPU's 16x8 program/data memory.

---
 rtl/prog_loader_if.sv | 25 ++
 rtl/prog_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Bus bundle between the program loader, the host UART line and the CPU
// memory/control side.
interface prog_loader_if;
  logic       rx;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic       err;

  // Loader side: consumes the UART line, drives memory write port and CPU control
  modport master (
    input  rx,
    output mem_we, mem_addr, mem_wdata, cpu_hold, cpu_rst, busy, done, err
  );

  // Host/CPU side: drives the UART line, observes everything else
  modport slave (
    output rx,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader: receives an 8N1 UART image (SYNC header + 16 bytes),
// writes it into the CPU's 16x8 memory, holds the CPU while loading and then
// pulses the CPU reset. Optional trailing checksum byte under LOADER_CKSUM_EN.
module prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned RST_CYCLES   = 1000000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  prog_loader_if.master bus
);

  localparam int unsigned BIT_CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned RST_CW = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
  localparam logic [BIT_CW-1:0] BIT_LAST  = BIT_CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CW-1:0] HALF_LAST = BIT_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [RST_CW-1:0] RST_LAST  = RST_CW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    S_WAIT_SYNC = 2'd0,
    S_LOAD      = 2'd1,
    S_RESET_CPU = 2'd2
`ifdef LOADER_CKSUM_EN
    , S_CHECK   = 2'd3
`endif
  } state_t;

  // UART receiver registers
  logic              r_rx_meta, r_rx_sync;
  rx_state_t         r_rx_state, w_rx_state_nxt;
  logic [BIT_CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]        r_rx_bit, w_rx_bit_nxt;
  logic [7:0]        r_rx_shift, w_rx_shift_nxt;
  logic              w_rx_valid, w_rx_ferr;

  // Loader FSM registers
  state_t            r_state, w_state_nxt;
  logic [3:0]        r_count, w_count_nxt;
  logic [RST_CW-1:0] r_rst_cnt, w_rst_cnt_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [3:0]        r_mem_addr, w_mem_addr_nxt;
  logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;
  logic              r_cpu_hold, w_cpu_hold_nxt;
  logic              r_cpu_rst, w_cpu_rst_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
`ifdef LOADER_CKSUM_EN
  logic [7:0]        r_cksum, w_cksum_nxt;
`endif

  // Receiver state, synchroniser and shift register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta  <= bus.rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  // Receiver next state: mid-bit sampling, LSB first, valid/framing strobes
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_valid     = 1'b0;
    w_rx_ferr      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt = '0;
          if (r_rx_sync) begin
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_rx_state_nxt = RX_DATA;
            w_rx_bit_nxt   = '0;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + BIT_CW'(1);
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) begin
            w_rx_state_nxt = RX_STOP;
          end else begin
            w_rx_bit_nxt = r_rx_bit + 3'd1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + BIT_CW'(1);
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt = '0;
          if (r_rx_sync) begin
            w_rx_valid     = 1'b1;
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_rx_ferr      = 1'b1;
            w_rx_state_nxt = RX_WAIT_HIGH;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + BIT_CW'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (r_rx_sync) w_rx_state_nxt = RX_IDLE;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // Loader state and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_WAIT_SYNC;
      r_count     <= '0;
      r_rst_cnt   <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b0;
      r_cpu_rst   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef LOADER_CKSUM_EN
      r_cksum     <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_rst_cnt   <= w_rst_cnt_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_cpu_hold  <= w_cpu_hold_nxt;
      r_cpu_rst   <= w_cpu_rst_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
`ifdef LOADER_CKSUM_EN
      r_cksum     <= w_cksum_nxt;
`endif
    end
  end

  // Loader next state: sync detect, memory writes, error handling, CPU reset pulse
  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_rst_cnt_nxt   = r_rst_cnt;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_cpu_hold_nxt  = r_cpu_hold;
    w_cpu_rst_nxt   = r_cpu_rst;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_err_nxt       = r_err;
`ifdef LOADER_CKSUM_EN
    w_cksum_nxt     = r_cksum;
`endif
    case (r_state)
      S_WAIT_SYNC: begin
        if (w_rx_valid && (r_rx_shift == SYNC_BYTE)) begin
          w_cpu_hold_nxt = 1'b1;
          w_busy_nxt     = 1'b1;
          w_done_nxt     = 1'b0;
          w_err_nxt      = 1'b0;
          w_count_nxt    = '0;
`ifdef LOADER_CKSUM_EN
          w_cksum_nxt    = '0;
`endif
          w_state_nxt    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_rx_ferr) begin
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_WAIT_SYNC;
        end else if (w_rx_valid) begin
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = r_count;
          w_mem_wdata_nxt = r_rx_shift;
          w_count_nxt     = r_count + 4'd1;
`ifdef LOADER_CKSUM_EN
          w_cksum_nxt     = r_cksum + r_rx_shift;
          if (r_count == 4'd15) w_state_nxt = S_CHECK;
`else
          if (r_count == 4'd15) begin
            w_cpu_rst_nxt = 1'b1;
            w_rst_cnt_nxt = '0;
            w_state_nxt   = S_RESET_CPU;
          end
`endif
        end
      end
`ifdef LOADER_CKSUM_EN
      S_CHECK: begin
        if (w_rx_ferr || (w_rx_valid && ((r_cksum + r_rx_shift) != 8'd0))) begin
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_WAIT_SYNC;
        end else if (w_rx_valid) begin
          w_cpu_rst_nxt = 1'b1;
          w_rst_cnt_nxt = '0;
          w_state_nxt   = S_RESET_CPU;
        end
      end
`endif
      S_RESET_CPU: begin
        if (r_rst_cnt == RST_LAST) begin
          w_cpu_rst_nxt  = 1'b0;
          w_cpu_hold_nxt = 1'b0;
          w_busy_nxt     = 1'b0;
          w_done_nxt     = 1'b1;
          w_state_nxt    = S_WAIT_SYNC;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RST_CW'(1);
        end
      end
      default: w_state_nxt = S_WAIT_SYNC;
    endcase
  end

  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cpu_hold  = r_cpu_hold;
  assign bus.cpu_rst   = r_cpu_rst;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule
